decode_stage: RTL

//  Registered RV32I instruction-decode stage. Turns a fetched instruction into the ALU

---
 rtl/pearl_pkg.sv | 61 ++++++
 rtl/decode_comb.sv | 142 ++++++++++++++
 rtl/decode_stage.sv | 101 ++++++++++
 3 files changed

// File: rtl/pearl_pkg.sv
// Shared types for the RV32I decode stage: ALU control encoding, opcodes,
// operand selects and the decoded payload word carried through the pipeline register.
package pearl_pkg;

    localparam int unsigned IMM_W = 32;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SLL  = 3'd1,
        ALU_SLT  = 3'd2,
        ALU_SLTU = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_SR   = 3'd5,
        ALU_OR   = 3'd6,
        ALU_AND  = 3'd7
    } alu_op_e;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111
    } opcode_e;

    typedef enum logic [1:0] {
        OP1_RS1  = 2'd0,
        OP1_PC   = 2'd1,
        OP1_ZERO = 2'd2
    } op1_sel_e;

    typedef enum logic {
        OP2_RS2 = 1'b0,
        OP2_IMM = 1'b1
    } op2_sel_e;

    typedef struct packed {
        alu_op_e          alu_op;
        logic             sbtr;
        logic             shdir;
        op1_sel_e         op1_sel;
        op2_sel_e         op2_sel;
        logic [IMM_W-1:0] imm;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic             reg_we;
        logic             mem_re;
        logic             mem_we;
        logic [2:0]       mem_size;
        logic             branch;
        logic             jump;
        logic             br_neg;
        logic             illegal;
    } decoded_t;

endpackage

// File: rtl/decode_comb.sv
// Pure combinational RV32I decoder: raw instruction to decoded_t payload.
// Illegal encodings produce an all-zero word with only the illegal flag set.
module decode_comb
    import pearl_pkg::*;
(
    input  logic [31:0] instr_i,
    output decoded_t    dec_o
);

    logic [2:0]       f3_s;
    logic [6:0]       f7_s;
    logic [4:0]       rd_s;
    logic [4:0]       rs1_s;
    logic [4:0]       rs2_s;
    logic [IMM_W-1:0] imm_i_s;
    logic [IMM_W-1:0] imm_s_s;
    logic [IMM_W-1:0] imm_b_s;
    logic [IMM_W-1:0] imm_u_s;
    logic [IMM_W-1:0] imm_j_s;
    decoded_t         raw_s;
    logic             bad_s;

    assign f3_s    = instr_i[14:12];
    assign f7_s    = instr_i[31:25];
    assign rd_s    = instr_i[11:7];
    assign rs1_s   = instr_i[19:15];
    assign rs2_s   = instr_i[24:20];
    assign imm_i_s = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b_s = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u_s = {instr_i[31:12], 12'h000};
    assign imm_j_s = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    // Per-opcode field decode and legality check
    always_comb begin
        raw_s = '0;
        bad_s = 1'b0;
        case (instr_i[6:0])
            OPC_OP: begin
                raw_s.alu_op = alu_op_e'(f3_s);
                raw_s.sbtr   = instr_i[30] & (f3_s == 3'd0);
                raw_s.shdir  = instr_i[30] & (f3_s == 3'd5);
                raw_s.rs1    = rs1_s;
                raw_s.rs2    = rs2_s;
                raw_s.rd     = rd_s;
                raw_s.reg_we = 1'b1;
                if (f7_s == 7'h00) begin
                    bad_s = 1'b0;
                end else if (f7_s == 7'h20) begin
                    bad_s = !((f3_s == 3'd0) || (f3_s == 3'd5));
                end else begin
                    bad_s = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                raw_s.alu_op  = alu_op_e'(f3_s);
                raw_s.shdir   = instr_i[30] & (f3_s == 3'd5);
                raw_s.op2_sel = OP2_IMM;
                raw_s.imm     = imm_i_s;
                raw_s.rs1     = rs1_s;
                raw_s.rd      = rd_s;
                raw_s.reg_we  = 1'b1;
                if (f3_s == 3'd1) begin
                    bad_s = (f7_s != 7'h00);
                end else if (f3_s == 3'd5) begin
                    bad_s = !((f7_s == 7'h00) || (f7_s == 7'h20));
                end else begin
                    bad_s = 1'b0;
                end
            end
            OPC_LUI, OPC_AUIPC: begin
                raw_s.op1_sel = (instr_i[5] == 1'b1) ? OP1_ZERO : OP1_PC;
                raw_s.op2_sel = OP2_IMM;
                raw_s.imm     = imm_u_s;
                raw_s.rd      = rd_s;
                raw_s.reg_we  = 1'b1;
            end
            OPC_LOAD: begin
                raw_s.op2_sel  = OP2_IMM;
                raw_s.imm      = imm_i_s;
                raw_s.rs1      = rs1_s;
                raw_s.rd       = rd_s;
                raw_s.reg_we   = 1'b1;
                raw_s.mem_re   = 1'b1;
                raw_s.mem_size = f3_s;
            end
            OPC_STORE: begin
                raw_s.op2_sel  = OP2_IMM;
                raw_s.imm      = imm_s_s;
                raw_s.rs1      = rs1_s;
                raw_s.rs2      = rs2_s;
                raw_s.mem_we   = 1'b1;
                raw_s.mem_size = f3_s;
            end
            OPC_BRANCH: begin
                raw_s.imm    = imm_b_s;
                raw_s.rs1    = rs1_s;
                raw_s.rs2    = rs2_s;
                raw_s.branch = 1'b1;
                raw_s.br_neg = f3_s[0];
                case (f3_s[2:1])
                    2'b00:   raw_s.alu_op = ALU_XOR;
                    2'b10:   raw_s.alu_op = ALU_SLT;
                    2'b11:   raw_s.alu_op = ALU_SLTU;
                    default: bad_s        = 1'b1;
                endcase
            end
            OPC_JAL: begin
                raw_s.op1_sel = OP1_PC;
                raw_s.op2_sel = OP2_IMM;
                raw_s.imm     = imm_j_s;
                raw_s.rd      = rd_s;
                raw_s.reg_we  = 1'b1;
                raw_s.jump    = 1'b1;
            end
            OPC_JALR: begin
                raw_s.op2_sel = OP2_IMM;
                raw_s.imm     = imm_i_s;
                raw_s.rs1     = rs1_s;
                raw_s.rd      = rd_s;
                raw_s.reg_we  = 1'b1;
                raw_s.jump    = 1'b1;
                bad_s         = (f3_s != 3'd0);
            end
            default: bad_s = 1'b1;
        endcase
    end

    // Squash illegal words and suppress writeback to x0
    always_comb begin
        dec_o = raw_s;
        if (bad_s) begin
            dec_o         = '0;
            dec_o.illegal = 1'b1;
        end else if (raw_s.rd == 5'd0) begin
            dec_o.reg_we = 1'b0;
        end else begin
            dec_o.reg_we = raw_s.reg_we;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: decode_comb feeding one pipeline register
// with valid/ready handshake and a flush that kills held and incoming words.
module decode_stage
    import pearl_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [2:0]      alu_op_o,
    output logic            sbtr_o,
    output logic            shdir_o,
    output logic [1:0]      op1_sel_o,
    output logic            op2_sel_o,
    output logic [XLEN-1:0] imm_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic            reg_we_o,
    output logic            mem_re_o,
    output logic            mem_we_o,
    output logic [2:0]      mem_size_o,
    output logic            branch_o,
    output logic            jump_o,
    output logic            br_neg_o,
    output logic            illegal_o
);

    decoded_t        dec_s;
    decoded_t        dec_r;
    logic            out_valid_r;
    logic [XLEN-1:0] pc_r;
    logic            accept_s;

    decode_comb u_decode_comb (
        .instr_i (instr_i),
        .dec_o   (dec_s)
    );

    assign in_ready_o = !out_valid_r | out_ready_i;
    assign accept_s   = in_valid_i & in_ready_o & !flush_i;

    // Output valid: flush wins, then accept, then drain on ready
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_r <= 1'b0;
        end else if (flush_i) begin
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
        end else if (out_ready_i) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Payload loads only on an accepted transfer, otherwise holds bit-stable
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dec_r <= '0;
            pc_r  <= RESET_PC;
        end else if (accept_s) begin
            dec_r <= dec_s;
            pc_r  <= pc_i;
        end else begin
            dec_r <= dec_r;
            pc_r  <= pc_r;
        end
    end

    assign out_valid_o = out_valid_r;
    assign pc_o        = pc_r;
    assign alu_op_o    = dec_r.alu_op;
    assign sbtr_o      = dec_r.sbtr;
    assign shdir_o     = dec_r.shdir;
    assign op1_sel_o   = dec_r.op1_sel;
    assign op2_sel_o   = dec_r.op2_sel;
    assign imm_o       = dec_r.imm;
    assign rs1_o       = dec_r.rs1;
    assign rs2_o       = dec_r.rs2;
    assign rd_o        = dec_r.rd;
    assign reg_we_o    = dec_r.reg_we;
    assign mem_re_o    = dec_r.mem_re;
    assign mem_we_o    = dec_r.mem_we;
    assign mem_size_o  = dec_r.mem_size;
    assign branch_o    = dec_r.branch;
    assign jump_o      = dec_r.jump;
    assign br_neg_o    = dec_r.br_neg;
    assign illegal_o   = dec_r.illegal;

endmodule
